// File: rtl/wb_unit_pkg.sv
// wb_unit_pkg: shared types and constants for the writeback unit
package wb_unit_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int WB_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/wb_unit_if.sv
// wb_unit_if: execute-side, register-file and forwarding signals of the writeback unit
interface wb_unit_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        issue_stall;
  logic        ovf;
  logic [4:0]  fwd_rs;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  modport master (
    output alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data, rf_busy, fwd_rs,
    input  mem_ready, rf_we, rf_waddr, rf_wdata, issue_stall, ovf, fwd_hit, fwd_data
  );
  modport slave (
    input  alu_valid, alu_rd, alu_result, mem_valid, mem_rd, mem_data, rf_busy, fwd_rs,
    output mem_ready, rf_we, rf_waddr, rf_wdata, issue_stall, ovf, fwd_hit, fwd_data
  );
endinterface

// File: rtl/wb_unit_fifo.sv
// wb_fifo: result buffer with wrapping pointers; entries/read pointer exported when WB_FORWARD_EN is defined
module wb_fifo import wb_unit_pkg::*; #(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef WB_FORWARD_EN
  ,
  output wb_entry_t                ents [DEPTH],
  output logic [$clog2(DEPTH)-1:0] rptr_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wb_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  assign head  = mem[rptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
`ifdef WB_FORWARD_EN
  assign ents   = mem;
  assign rptr_o = rptr;
`endif
  // pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // storage needs no reset: only entries below count are ever observed
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
endmodule

// File: rtl/wb_unit.sv
// wb_unit: register-file writeback buffer (ALU/load arbitration, overflow, stall, forwarding under WB_FORWARD_EN)
module wb_unit import wb_unit_pkg::*; #(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input logic     clk,
  input logic     rstn,
  wb_unit_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wb_entry_t din, head;
  logic [AW:0] count;
  logic full, empty, pop, push, alu_push, mem_push;
  assign wb.mem_ready = !wb.alu_valid && !full;
  assign pop = !empty && !wb.rf_busy;
  assign alu_push = wb.alu_valid && wb.alu_rd != REG_ZERO && (!full || pop);
  assign mem_push = wb.mem_valid && wb.mem_ready && wb.mem_rd != REG_ZERO;
  assign push = alu_push || mem_push;
  assign din = wb.alu_valid ? {wb.alu_rd, wb.alu_result} : {wb.mem_rd, wb.mem_data};
  assign wb.issue_stall = count >= CW'(DEPTH - 1);
`ifdef WB_FORWARD_EN
  wb_entry_t ents [DEPTH];
  logic [AW-1:0] rptr, idx;
`endif
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
`ifdef WB_FORWARD_EN
    ,
    .ents  (ents),
    .rptr_o(rptr)
`endif
  );
  // register-file write port and sticky overflow
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wb.rf_we    <= 1'b0;
      wb.rf_waddr <= '0;
      wb.rf_wdata <= '0;
      wb.ovf      <= 1'b0;
    end else begin
      wb.rf_we <= pop;
      if (pop) {wb.rf_waddr, wb.rf_wdata} <= head;
      if (wb.alu_valid && full && !pop) wb.ovf <= 1'b1;
    end
`ifdef WB_FORWARD_EN
  // scan oldest to youngest so the last match wins
  always_comb begin
    wb.fwd_hit  = 1'b0;
    wb.fwd_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + AW'(i);
      if (CW'(i) < count && wb.fwd_rs != REG_ZERO && ents[idx].rd == wb.fwd_rs) begin
        wb.fwd_hit  = 1'b1;
        wb.fwd_data = ents[idx].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd  = ^wb.fwd_rs;
  assign wb.fwd_hit  = 1'b0;
  assign wb.fwd_data = '0;
`endif
endmodule
